reset_sequencer: RTL



---
 rtl/reset_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - master-clear synchroniser and staged reset release with soft-reset replay
`timescale 1ns/1ps

module reset_sequencer #(
   parameter int STAGES     = 3,
   parameter int GAP        = 4,
   parameter int SOFT_HOLD  = 8,
   parameter int CNT_W      = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic              Clk,
   input  logic              Clear_bar,
   input  logic              Soft_req,
   input  logic              Hold_bar,
   output logic [STAGES-1:0] Stage_bar,
   output logic              Ready,
   output logic              Soft_ack
);

   localparam int IDX_W = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(STAGES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SOFT_HOLD - 1);

   typedef enum logic [1:0] {
      RESET,
      RELEASE,
      RUN,
      SOFT
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [STAGES-1:0] stage_q, stage_d;
   logic              ready_q, ready_d;
   logic              ack_q, ack_d;
   logic              s1_q, s2_q;

   // The synchroniser only matters coming out of Clear_bar; afterwards it simply stays at 1.
   always_ff @(posedge Clk or negedge Clear_bar) begin
      if (!Clear_bar) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         state_q <= RESET;
         cnt_q   <= '0;
         idx_q   <= '0;
         stage_q <= '0;
         ready_q <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         s1_q    <= 1'b1;
         s2_q    <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         stage_q <= stage_d;
         ready_q <= ready_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      stage_d = stage_q;
      ready_d = ready_q;
      ack_d   = 1'b0;
      case (state_q)
         RESET: begin
            if (s2_q) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         RELEASE: begin
            if (Hold_bar) begin
               if (cnt_q == GAP_LAST) begin
                  stage_d[idx_q] = 1'b1;
                  cnt_d          = '0;
                  idx_d          = idx_q + 1'b1;
                  if (idx_q == IDX_LAST) begin
                     state_d = RUN;
                     ready_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         RUN: begin
            if (Soft_req) begin
               state_d = SOFT;
               stage_d = '0;
               ready_d = 1'b0;
               ack_d   = 1'b1;
               cnt_d   = '0;
            end
         end
         SOFT: begin
            // Soft replay skips the synchroniser: Clk domain is already known-good.
            if (cnt_q == HOLD_LAST) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = RESET;
      endcase
   end

   if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_nodly
      assign Stage_bar = stage_q;
      assign Ready     = ready_q;
      assign Soft_ack  = ack_q;
   end else begin : g_dly
      assign #(DELAY_RISE, DELAY_FALL) Stage_bar = stage_q;
      assign #(DELAY_RISE, DELAY_FALL) Ready     = ready_q;
      assign #(DELAY_RISE, DELAY_FALL) Soft_ack  = ack_q;
   end

endmodule
